// File: rtl/pixel_mem_pkg.sv
// Shared types and default widths for the pixel RAM arbiter and its CPU-side users.
package pixel_mem_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

  typedef enum logic {
    ARB_IDLE,
    ARB_CLEAR
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_SCAN,
    GNT_CLEAR,
    GNT_CPU
  } grant_t;

endpackage

// File: rtl/pixel_mem_arbiter_if.sv
// Requester and RAM-side signals of the pixel arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface pixel_mem_arbiter_if
  import pixel_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              scan_req;
  logic [ADDR_W-1:0] scan_addr;
  logic              scan_valid;
  logic [DATA_W-1:0] scan_pixel;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_stall;
  logic              clear_start;
  logic              clear_busy;
  logic              clear_done;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output scan_req, scan_addr, cpu_we, cpu_addr, cpu_data, clear_start, mem_rdata,
    input  scan_valid, scan_pixel, cpu_stall, clear_busy, clear_done,
           mem_addr, mem_wdata, mem_wren
  );

  modport slave (
    input  scan_req, scan_addr, cpu_we, cpu_addr, cpu_data, clear_start, mem_rdata,
    output scan_valid, scan_pixel, cpu_stall, clear_busy, clear_done,
           mem_addr, mem_wdata, mem_wren
  );

endinterface

// File: rtl/pixel_wr_fifo.sv
// Synchronous FIFO of buffered CPU pixel writes; head is the oldest entry.
// Pushes while full and pops while empty are ignored; full/empty are registered.
module pixel_wr_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [PTR_W:0]   w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;

  assign w_push = push && !r_full;
  assign w_pop  = pop && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + (PTR_W+1)'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_FULL);
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage is not reset; the empty flag guards every read of it.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end

  assign full  = r_full;
  assign empty = r_empty;
  assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/pixel_mem_arbiter.sv
// Shares one single-port pixel RAM between scan-out reads, buffered CPU writes and a frame-clear sweep.
// Fixed priority scan > clear > CPU; the CPU is stalled only when its write buffer is full.
module pixel_mem_arbiter
  import pixel_mem_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                FIFO_DEPTH  = 4,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input logic                clk,
  input logic                reset,
  pixel_mem_arbiter_if.slave bus
);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  grant_t             w_grant;
  logic [ADDR_W-1:0]  r_clr_cnt;
  logic [ADDR_W-1:0]  r_last_addr;
  logic               r_scan_valid;
  logic               r_clear_done;
  logic               w_clr_last;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_wdata;
  logic               w_wren;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_push;
  logic               w_pop;
  logic [ADDR_W+DATA_W-1:0] w_head;

  assign w_clr_last = (r_clr_cnt == '1);
  assign w_push     = bus.cpu_we && !w_fifo_full;
  assign w_pop      = (w_grant == GNT_CPU);

  pixel_wr_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .wdata ({bus.cpu_addr, bus.cpu_data}),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .head  (w_head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = GNT_NONE;
    if (bus.scan_req) begin
      w_grant = GNT_SCAN;
    end else if (r_state == ARB_CLEAR) begin
      w_grant = GNT_CLEAR;
    end else if (!w_fifo_empty) begin
      w_grant = GNT_CPU;
    end

    case (r_state)
      ARB_IDLE:  if (bus.clear_start) w_state_nxt = ARB_CLEAR;
      ARB_CLEAR: if (w_grant == GNT_CLEAR && w_clr_last) w_state_nxt = ARB_IDLE;
      default:   w_state_nxt = ARB_IDLE;
    endcase
  end

  // Idle cycles keep the previous address so the RAM address bus does not toggle.
  always_comb begin
    w_addr  = r_last_addr;
    w_wdata = '0;
    w_wren  = 1'b0;
    case (w_grant)
      GNT_SCAN: begin
        w_addr = bus.scan_addr;
      end
      GNT_CLEAR: begin
        w_addr  = r_clr_cnt;
        w_wdata = CLEAR_VALUE;
        w_wren  = 1'b1;
      end
      GNT_CPU: begin
        w_addr  = w_head[ADDR_W+DATA_W-1:DATA_W];
        w_wdata = w_head[DATA_W-1:0];
        w_wren  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_cnt    <= '0;
      r_last_addr  <= '0;
      r_scan_valid <= 1'b0;
      r_clear_done <= 1'b0;
    end else begin
      if (r_state == ARB_IDLE && bus.clear_start) begin
        r_clr_cnt <= '0;
      end else if (w_grant == GNT_CLEAR) begin
        r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
      end
      r_last_addr  <= w_addr;
      r_scan_valid <= bus.scan_req;
      r_clear_done <= (w_grant == GNT_CLEAR) && w_clr_last;
    end
  end

  assign bus.mem_addr   = reset ? '0 : w_addr;
  assign bus.mem_wdata  = reset ? '0 : w_wdata;
  assign bus.mem_wren   = reset ? 1'b0 : w_wren;
  assign bus.scan_valid = r_scan_valid;
  assign bus.scan_pixel = r_scan_valid ? bus.mem_rdata : '0;
  assign bus.cpu_stall  = w_fifo_full;
  assign bus.clear_busy = (r_state == ARB_CLEAR);
  assign bus.clear_done = r_clear_done;

endmodule

// File: tb/tb_pixel_mem_arbiter.sv
// Scoreboard bench for pixel_mem_arbiter (ADDR_W=4 build) with a registered-read RAM model.
module tb_pixel_mem_arbiter;

  typedef struct {
    int         idx;
    logic [3:0] addr;
    logic [7:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic       pre_we;
  logic [3:0] pre_addr;
  logic [7:0] pre_dat;
  logic [7:0] ram [16];

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  exp_scan [$];
  logic [11:0] exp_wr [$];
  ev_t         scan_tab [$];
  ev_t         cpu_tab [$];

  pixel_mem_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  pixel_mem_arbiter #(
    .ADDR_W      (4),
    .DATA_W      (8),
    .FIFO_DEPTH  (4),
    .CLEAR_VALUE (8'h00)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_dat;
    else if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor_step();
    if (bus.scan_valid) begin
      if (exp_scan.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL scan_unexpected: got pixel %0h, expected no scan_valid", bus.scan_pixel);
      end else begin
        check("scan_pixel", 32'(bus.scan_pixel), 32'(exp_scan.pop_front()));
      end
    end
    if (bus.mem_wren) begin
      if (exp_wr.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL write_unexpected: got addr %0h data %0h, expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        check("mem_write", 32'({bus.mem_addr, bus.mem_wdata}), 32'(exp_wr.pop_front()));
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_scan_valid"}, 32'(bus.scan_valid), 0);
    check({tag, "_scan_pixel"}, 32'(bus.scan_pixel), 0);
    check({tag, "_cpu_stall"},  32'(bus.cpu_stall), 0);
    check({tag, "_clear_busy"}, 32'(bus.clear_busy), 0);
    check({tag, "_clear_done"}, 32'(bus.clear_done), 0);
    check({tag, "_mem_wren"},   32'(bus.mem_wren), 0);
    check({tag, "_mem_addr"},   32'(bus.mem_addr), 0);
    check({tag, "_mem_wdata"},  32'(bus.mem_wdata), 0);
  endtask

  // Full sweep; scan_tab/cpu_tab inject traffic at given busy-cycle indices.
  task automatic sweep(input int exp_busy, input string tag);
    int busy_cnt = 0;
    bit fin = 0;
    bus.clear_start = 1'b1;
    for (int i = 0; i < 16; i++) exp_wr.push_back({4'(i), 8'h00});
    tick();
    bus.clear_start = 1'b0;
    for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
      bus.scan_req = 1'b0;
      bus.cpu_we   = 1'b0;
      if (bus.clear_busy) begin
        foreach (scan_tab[k]) begin
          if (scan_tab[k].idx == busy_cnt) begin
            bus.scan_req  = 1'b1;
            bus.scan_addr = scan_tab[k].addr;
            exp_scan.push_back(scan_tab[k].val);
          end
        end
        foreach (cpu_tab[k]) begin
          if (cpu_tab[k].idx == busy_cnt) begin
            bus.cpu_we   = 1'b1;
            bus.cpu_addr = cpu_tab[k].addr;
            bus.cpu_data = cpu_tab[k].val;
            exp_wr.push_back({cpu_tab[k].addr, cpu_tab[k].val});
          end
        end
        busy_cnt++;
        tick();
      end else begin
        check({tag, "_done_pulse"}, 32'(bus.clear_done), 1);
        fin = 1;
      end
    end
    if (!fin) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: got clear_busy still high, expected it low within 40 cycles", tag);
    end
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
  endtask

  initial begin
    rst = 1'b1;
    pre_we = 1'b0; pre_addr = '0; pre_dat = '0;
    bus.scan_req = 1'b0; bus.scan_addr = '0;
    bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_data = '0;
    bus.clear_start = 1'b0;

    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
      begin
        #200000;
        n_vec++; n_err++;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
      end
    join_none

    // Preload ram[i] = 0x50+i, so ram[0xA] = 0x5A.
    repeat (2) tick();
    for (int i = 0; i < 16; i++) begin
      pre_we = 1'b1; pre_addr = 4'(i); pre_dat = 8'h50 + 8'(i);
      tick();
    end
    pre_we = 1'b0;
    rst = 1'b0;
    tick();
    check_reset_vals("rst");

    // Single scan read.
    bus.scan_req = 1'b1; bus.scan_addr = 4'hA; exp_scan.push_back(8'h5A);
    tick();
    bus.scan_req = 1'b0;
    check("scan_latency", 32'(bus.scan_valid), 1);
    tick();

    // Idle CPU write, then read it back.
    bus.cpu_we = 1'b1; bus.cpu_addr = 4'h4; bus.cpu_data = 8'hC3;
    exp_wr.push_back({4'h4, 8'hC3});
    tick();
    bus.cpu_we = 1'b0;
    check("cpu_latency_wren", 32'(bus.mem_wren), 1);
    check("cpu_latency_addr", 32'(bus.mem_addr), 32'h4);
    tick();
    bus.scan_req = 1'b1; bus.scan_addr = 4'h4; exp_scan.push_back(8'hC3);
    tick();
    bus.scan_req = 1'b0;
    tick();

    // Back-pressure under continuous scan.
    bus.scan_req = 1'b1; bus.scan_addr = 4'h0;
    for (int k = 0; k < 4; k++) begin
      check("bp_stall_low", 32'(bus.cpu_stall), 0);
      bus.cpu_we = 1'b1; bus.cpu_addr = 4'(k + 1); bus.cpu_data = 8'hD0 + 8'(k);
      exp_wr.push_back({4'(k + 1), 8'hD0 + 8'(k)});
      exp_scan.push_back(8'h50);
      tick();
    end
    bus.cpu_addr = 4'h5; bus.cpu_data = 8'hD4;
    for (int k = 0; k < 3; k++) begin
      check("bp_stall_high", 32'(bus.cpu_stall), 1);
      exp_scan.push_back(8'h50);
      tick();
    end
    bus.cpu_we = 1'b0; bus.scan_req = 1'b0;
    repeat (4) tick();
    check("bp_drained", 32'(exp_wr.size()), 0);
    check("bp_stall_released", 32'(bus.cpu_stall), 0);

    // Clear sweep with three scan interruptions: ram[1..4] = D0..D3 beforehand.
    scan_tab.push_back('{idx: 2,  addr: 4'hA, val: 8'h5A});
    scan_tab.push_back('{idx: 5,  addr: 4'h2, val: 8'h00});
    scan_tab.push_back('{idx: 10, addr: 4'hF, val: 8'h5F});
    sweep(19, "clr");
    tick();
    check("clr_done_one_cycle", 32'(bus.clear_done), 0);
    scan_tab.delete();
    repeat (2) tick();

    // CPU writes queued mid-sweep land after the clear.
    cpu_tab.push_back('{idx: 4, addr: 4'h6, val: 8'h66});
    cpu_tab.push_back('{idx: 5, addr: 4'h7, val: 8'h77});
    sweep(16, "cpuclr");
    cpu_tab.delete();
    tick();
    check("cpuclr_done_one_cycle", 32'(bus.clear_done), 0);
    tick();
    bus.scan_req = 1'b1; bus.scan_addr = 4'h6; exp_scan.push_back(8'h66);
    tick();
    bus.scan_addr = 4'h7; exp_scan.push_back(8'h77);
    tick();
    bus.scan_req = 1'b0;
    repeat (2) tick();

    // Reset at clr_cnt=7 with two buffered writes, then restart.
    bus.clear_start = 1'b1;
    for (int i = 0; i < 7; i++) exp_wr.push_back({4'(i), 8'h00});
    tick();
    bus.clear_start = 1'b0;
    for (int j = 0; j < 7; j++) begin
      bus.cpu_we = (j == 1) || (j == 2);
      bus.cpu_addr = 4'(8 + j); bus.cpu_data = 8'h80 + 8'(j);
      tick();
    end
    bus.cpu_we = 1'b0;
    check("rc_busy_before_reset", 32'(bus.clear_busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_vals("rc");
    repeat (6) tick();
    sweep(16, "restart");
    repeat (3) tick();

    check("end_scan_queue", 32'(exp_scan.size()), 0);
    check("end_write_queue", 32'(exp_wr.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
